// File: rtl/isqrt_pkg.sv
// Shared types and sizing helpers for the iterative integer square-root unit.
package isqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // One result bit is produced per iteration, so a WIDTH-bit radicand needs WIDTH/2 steps.
   function automatic int unsigned iter_count(input int unsigned width);
      return width / 2;
   endfunction

   // The remainder accumulator needs two bits of headroom over the root for the shifted-in pair.
   function automatic int unsigned acc_width(input int unsigned width);
      return width / 2 + 2;
   endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: fold in two radicand bits and decide the next root bit.
module isqrt_step
   import isqrt_pkg::*;
#(
   parameter int unsigned HW = 8,
   parameter int unsigned AW = acc_width(2 * HW)
) (
   input  logic [AW-1:0] r,
   input  logic [HW-1:0] root,
   input  logic [1:0]    bits,
   output logic [AW-1:0] r_next,
   output logic [HW-1:0] root_next
);

   logic [AW-1:0] r_sh;
   logic [AW-1:0] trial;

   always_comb begin
      r_sh      = AW'(r << 2) | AW'(bits);
      trial     = AW'({root, 2'b01});
      r_next    = r_sh;
      root_next = HW'({root, 1'b0});
      if (r_sh >= trial) begin
         r_next    = r_sh - trial;
         root_next = HW'({root, 1'b1});
      end
   end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root: go/over handshake, one root bit per clock, back-to-back issue from DONE.
module isqrt_seq
   import isqrt_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter bit          HOLD_GO = 1'b0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               go,
   input  logic [WIDTH-1:0]   n,
   output logic [WIDTH/2-1:0] answer,
   output logic [WIDTH/2:0]   remainder,
   output logic               busy,
   output logic               over
);

   localparam int unsigned HW = iter_count(WIDTH);
   localparam int unsigned AW = acc_width(WIDTH);
   localparam int unsigned RW = HW + 1;
   localparam int unsigned KW = (HW > 1) ? $clog2(HW) : 1;

   if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("isqrt_seq: WIDTH must be even and at least 2");
   end

   state_t           state, state_nxt;
   logic [KW-1:0]    k, k_nxt;
   logic [WIDTH-1:0] opnd, opnd_nxt;
   logic [AW-1:0]    acc, acc_nxt, acc_step;
   logic [HW-1:0]    root, root_nxt, root_step;
   logic [HW-1:0]    answer_nxt;
   logic [RW-1:0]    remainder_nxt;
   logic             busy_nxt, over_nxt;
   logic             go_q;
   logic             accept;

   isqrt_step #(.HW(HW), .AW(AW)) u_step (
      .r         (acc),
      .root      (root),
      .bits      (opnd[WIDTH-1 -: 2]),
      .r_next    (acc_step),
      .root_next (root_step)
   );

   // Without HOLD_GO a level-high go must drop for one edge before it can start another run.
   assign accept = go && (state == IDLE || state == DONE) && (HOLD_GO || !go_q);

   always_comb begin
      state_nxt     = state;
      k_nxt         = k;
      opnd_nxt      = opnd;
      acc_nxt       = acc;
      root_nxt      = root;
      answer_nxt    = answer;
      remainder_nxt = remainder;
      busy_nxt      = busy;
      over_nxt      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               state_nxt = CALC;
               k_nxt     = KW'(HW - 1);
               opnd_nxt  = n;
               acc_nxt   = '0;
               root_nxt  = '0;
               busy_nxt  = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         CALC: begin
            acc_nxt  = acc_step;
            root_nxt = root_step;
            opnd_nxt = WIDTH'(opnd << 2);
            if (k == '0) begin
               answer_nxt    = root_step;
               remainder_nxt = RW'(acc_step);
               busy_nxt      = 1'b0;
               over_nxt      = 1'b1;
               state_nxt     = DONE;
            end else begin
               k_nxt = k - KW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         k         <= '0;
         opnd      <= '0;
         acc       <= '0;
         root      <= '0;
         answer    <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         over      <= 1'b0;
         go_q      <= 1'b0;
      end else begin
         state     <= state_nxt;
         k         <= k_nxt;
         opnd      <= opnd_nxt;
         acc       <= acc_nxt;
         root      <= root_nxt;
         answer    <= answer_nxt;
         remainder <= remainder_nxt;
         busy      <= busy_nxt;
         over      <= over_nxt;
         go_q      <= go;
      end
   end

endmodule
